// File: rtl/pong_score_ctrl_pkg.sv
// Shared definitions for the pong score controller: state encoding, digit
// bitmap geometry and the bitmap bit-index helper.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    localparam logic [1:0] ST_SERVE     = SERVE;
    localparam logic [1:0] ST_PLAY      = PLAY;
    localparam logic [1:0] ST_GAME_OVER = GAME_OVER;

    localparam int DIGIT_W  = 10;
    localparam int DIGIT_H  = 35;
    localparam int BITMAP_W = 350;

    // Row-major bitmap addressing: row 0 is the top row, col 0 the leftmost pixel.
    function automatic logic [9:0] bit_index(input logic [5:0] row, input logic [3:0] col);
        return 10'(row) * 10'(DIGIT_W) + 10'(col);
    endfunction

endpackage

// File: rtl/pong_score_ctrl_render.sv
// Score display: frame-start shadow latch plus the two-stage pixel pipeline
// that time-shares the digit ROM between the P1 and P2 score windows.
module pong_score_render
    import pong_pkg::*;
#(
    parameter int LEFT_X  = 240,
    parameter int RIGHT_X = 390,
    parameter int DIGIT_Y = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          hpos,
    input  logic [9:0]          vpos,
    input  logic [3:0]          p1_score,
    input  logic [3:0]          p2_score,
    input  logic [BITMAP_W-1:0] digit_bits,
    output logic [3:0]          digit_sel,
    output logic                pixel_on
);

    localparam logic [9:0] LX0 = 10'(LEFT_X);
    localparam logic [9:0] LX1 = 10'(LEFT_X + DIGIT_W);
    localparam logic [9:0] RX0 = 10'(RIGHT_X);
    localparam logic [9:0] RX1 = 10'(RIGHT_X + DIGIT_W);
    localparam logic [9:0] Y0  = 10'(DIGIT_Y);
    localparam logic [9:0] Y1  = 10'(DIGIT_Y + DIGIT_H);

    logic [3:0] r_disp1, r_disp2;
    logic       r_hit_l, r_hit_r;
    logic [5:0] r_row;
    logic [3:0] r_col;
    logic [3:0] r_digit_sel;
    logic       r_pixel;

    logic       w_in_y, w_in_l, w_in_r;
    logic [3:0] w_col_l, w_col_r;
    logic [5:0] w_row;
    logic [9:0] w_bit_idx;
    logic       w_rom_bit;

    assign w_in_y    = (vpos >= Y0) && (vpos < Y1);
    assign w_in_l    = w_in_y && (hpos >= LX0) && (hpos < LX1);
    assign w_in_r    = w_in_y && (hpos >= RX0) && (hpos < RX1);
    assign w_col_l   = 4'(hpos - LX0);
    assign w_col_r   = 4'(hpos - RX0);
    assign w_row     = 6'(vpos - Y0);
    assign w_bit_idx = bit_index(r_row, r_col);

    // ROM bit lookup; row/col are junk outside the windows, so guard the range.
    always_comb begin
        w_rom_bit = 1'b0;
        if (w_bit_idx < 10'(BITMAP_W)) begin
            w_rom_bit = digit_bits[w_bit_idx[8:0]];
        end else begin
            w_rom_bit = 1'b0;
        end
    end

    // Shadow latch at frame origin and the two pipeline stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_disp1     <= 4'd0;
            r_disp2     <= 4'd0;
            r_hit_l     <= 1'b0;
            r_hit_r     <= 1'b0;
            r_row       <= 6'd0;
            r_col       <= 4'd0;
            r_digit_sel <= 4'd0;
            r_pixel     <= 1'b0;
        end else begin
            if ((hpos == 10'd0) && (vpos == 10'd0)) begin
                r_disp1 <= p1_score;
                r_disp2 <= p2_score;
            end else begin
                r_disp1 <= r_disp1;
                r_disp2 <= r_disp2;
            end
            r_hit_l     <= w_in_l;
            r_hit_r     <= w_in_r;
            r_row       <= w_row;
            r_col       <= w_in_r ? w_col_r : w_col_l;
            r_digit_sel <= w_in_r ? r_disp2 : r_disp1;
            r_pixel     <= (r_hit_l | r_hit_r) & w_rom_bit;
        end
    end

    assign digit_sel = r_digit_sel;
    assign pixel_on  = r_pixel;

endmodule

// File: rtl/pong_score_ctrl.sv
// Pong score controller: score keeping, serve/play/game-over sequencing and
// the score-digit renderer driving the shared digit ROM.
module pong_score_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 9,
    parameter int HOLD_CYCLES = 25000000,
    parameter int LEFT_X      = 240,
    parameter int RIGHT_X     = 390,
    parameter int DIGIT_Y     = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                p1_point,
    input  logic                p2_point,
    input  logic                new_game,
    input  logic [9:0]          hpos,
    input  logic [9:0]          vpos,
    input  logic [BITMAP_W-1:0] digit_bits,
    output logic [3:0]          digit_sel,
    output logic                pixel_on,
    output logic                serving,
    output logic                game_over,
    output logic                winner,
    output logic [3:0]          p1_score,
    output logic [3:0]          p2_score
);

    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [3:0]  WIN_VAL   = 4'(WIN_SCORE);

    logic [1:0]  r_state;
    logic [31:0] r_hold_cnt;
    logic [3:0]  r_p1_score, r_p2_score;
    logic        r_winner, r_serving, r_game_over;

    logic [1:0]  w_state_nx;
    logic [31:0] w_hold_nx;
    logic [3:0]  w_p1_nx, w_p2_nx, w_p1_inc, w_p2_inc;
    logic        w_winner_nx;

    assign w_p1_inc = r_p1_score + 4'd1;
    assign w_p2_inc = r_p2_score + 4'd1;

    // Next-state and score update; new_game wins over everything, P1 over P2.
    always_comb begin
        w_state_nx  = r_state;
        w_hold_nx   = r_hold_cnt;
        w_p1_nx     = r_p1_score;
        w_p2_nx     = r_p2_score;
        w_winner_nx = r_winner;
        if (new_game) begin
            w_state_nx  = ST_SERVE;
            w_hold_nx   = 32'd0;
            w_p1_nx     = 4'd0;
            w_p2_nx     = 4'd0;
            w_winner_nx = 1'b0;
        end else begin
            case (r_state)
                ST_SERVE: begin
                    if (r_hold_cnt >= HOLD_LAST) begin
                        w_state_nx = ST_PLAY;
                        w_hold_nx  = 32'd0;
                    end else begin
                        w_hold_nx  = r_hold_cnt + 32'd1;
                    end
                end
                ST_PLAY: begin
                    if (p1_point) begin
                        w_p1_nx = w_p1_inc;
                        if (w_p1_inc == WIN_VAL) begin
                            w_state_nx  = ST_GAME_OVER;
                            w_winner_nx = 1'b0;
                        end else begin
                            w_state_nx = ST_SERVE;
                            w_hold_nx  = 32'd0;
                        end
                    end else if (p2_point) begin
                        w_p2_nx = w_p2_inc;
                        if (w_p2_inc == WIN_VAL) begin
                            w_state_nx  = ST_GAME_OVER;
                            w_winner_nx = 1'b1;
                        end else begin
                            w_state_nx = ST_SERVE;
                            w_hold_nx  = 32'd0;
                        end
                    end else begin
                        w_state_nx = ST_PLAY;
                    end
                end
                ST_GAME_OVER: begin
                    w_state_nx = ST_GAME_OVER;
                end
                default: begin
                    w_state_nx = ST_SERVE;
                    w_hold_nx  = 32'd0;
                end
            endcase
        end
    end

    // Game state registers; status flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_SERVE;
            r_hold_cnt  <= 32'd0;
            r_p1_score  <= 4'd0;
            r_p2_score  <= 4'd0;
            r_winner    <= 1'b0;
            r_serving   <= 1'b1;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_hold_cnt  <= w_hold_nx;
            r_p1_score  <= w_p1_nx;
            r_p2_score  <= w_p2_nx;
            r_winner    <= w_winner_nx;
            r_serving   <= (w_state_nx == ST_SERVE);
            r_game_over <= (w_state_nx == ST_GAME_OVER);
        end
    end

    assign serving   = r_serving;
    assign game_over = r_game_over;
    assign winner    = r_winner;
    assign p1_score  = r_p1_score;
    assign p2_score  = r_p2_score;

    pong_score_render #(
        .LEFT_X  (LEFT_X),
        .RIGHT_X (RIGHT_X),
        .DIGIT_Y (DIGIT_Y)
    ) u_render (
        .clk        (clk),
        .rst_n      (rst_n),
        .hpos       (hpos),
        .vpos       (vpos),
        .p1_score   (r_p1_score),
        .p2_score   (r_p2_score),
        .digit_bits (digit_bits),
        .digit_sel  (digit_sel),
        .pixel_on   (pixel_on)
    );

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Self-checking bench for pong_score_ctrl with a behavioural game/raster model
// and a procedural digit ROM attached to digit_sel/digit_bits.
module tb_pong_score_ctrl;

    localparam int WIN  = 3;
    localparam int HOLD = 4;
    localparam int LX   = 240;
    localparam int RX   = 390;
    localparam int DY   = 40;

    logic         clk = 1'b0;
    logic         rst_n, p1_point, p2_point, new_game;
    logic [9:0]   hpos, vpos;
    logic [349:0] digit_bits;
    logic [3:0]   digit_sel, p1_score, p2_score;
    logic         pixel_on, serving, game_over, winner;

    int n_checks = 0;
    int n_fail   = 0;

    // Game model: 0 = serving, 1 = rally in progress, 2 = match decided
    int   m_state, m_serve_left, m_p1, m_p2, m_d1, m_d2, m_sel;
    logic m_win, m_px_s1, m_px;

    always #5 clk = ~clk;

    pong_score_ctrl #(
        .WIN_SCORE(WIN), .HOLD_CYCLES(HOLD), .LEFT_X(LX), .RIGHT_X(RX), .DIGIT_Y(DY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .p1_point(p1_point), .p2_point(p2_point),
        .new_game(new_game), .hpos(hpos), .vpos(vpos), .digit_bits(digit_bits),
        .digit_sel(digit_sel), .pixel_on(pixel_on), .serving(serving),
        .game_over(game_over), .winner(winner), .p1_score(p1_score), .p2_score(p2_score)
    );

    // Digit "1" has a solid top row; other pixels follow a diagonal pattern.
    function automatic logic rom_bit(input int d, input int r, input int c);
        if (d == 1 && r == 0) return 1'b1;
        return ((r + c + d) % 3) == 0;
    endfunction

    function automatic logic [349:0] rom_bits(input logic [3:0] d);
        logic [349:0] b;
        b = '0;
        for (int r = 0; r < 35; r++)
            for (int c = 0; c < 10; c++)
                b[r*10 + c] = rom_bit(int'(d), r, c);
        return b;
    endfunction

    assign digit_bits = rom_bits(digit_sel);

    task automatic model_reset();
        m_state = 0; m_serve_left = HOLD; m_p1 = 0; m_p2 = 0; m_win = 1'b0;
        m_d1 = 0; m_d2 = 0; m_sel = 0; m_px_s1 = 1'b0; m_px = 1'b0;
    endtask

    task automatic tick(input logic a, input logic b, input logic g);
        int h, v;
        logic hl, hr, px;
        p1_point = a; p2_point = b; new_game = g;
        h = int'(hpos); v = int'(vpos);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            hl = (h >= LX) && (h < LX + 10) && (v >= DY) && (v < DY + 35);
            hr = (h >= RX) && (h < RX + 10) && (v >= DY) && (v < DY + 35);
            px = hl ? rom_bit(m_d1, v - DY, h - LX) : (hr ? rom_bit(m_d2, v - DY, h - RX) : 1'b0);
            m_px = m_px_s1; m_px_s1 = px; m_sel = hr ? m_d2 : m_d1;
            if (h == 0 && v == 0) begin m_d1 = m_p1; m_d2 = m_p2; end
            if (g) begin
                m_state = 0; m_serve_left = HOLD; m_p1 = 0; m_p2 = 0; m_win = 1'b0;
            end else if (m_state == 0) begin
                m_serve_left--;
                if (m_serve_left == 0) m_state = 1;
            end else if (m_state == 1 && (a || b)) begin
                if (a) m_p1++; else m_p2++;
                if ((a ? m_p1 : m_p2) == WIN) begin m_state = 2; m_win = !a; end
                else begin m_state = 0; m_serve_left = HOLD; end
            end
        end
        #1;
        p1_point = 1'b0; p2_point = 1'b0; new_game = 1'b0;
    endtask

    task automatic wait_play();
        int n;
        n = 0;
        while (serving !== 1'b0 && n < 20) begin tick(0, 0, 0); n++; end
        if (serving !== 1'b0) begin
            n_checks++; n_fail++;
            $display("FAIL wait_play timeout: serving=%b required 0", serving);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick(0, 0, 0);
        rst_n = 1'b1;
        n_checks++;
        if ({p1_score, p2_score, pixel_on, game_over, winner, digit_sel, serving} !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: p1=%0d p2=%0d pix=%b go=%b win=%b sel=%0d srv=%b required 0 0 0 0 0 0 1",
                     p1_score, p2_score, pixel_on, game_over, winner, digit_sel, serving);
        end
        for (int i = 1; i <= 4; i++) begin
            tick(0, 0, 0);
            n_checks++;
            if (serving !== (i < 4)) begin
                n_fail++;
                $display("FAIL serve_hold cycle %0d: serving=%b required %b", i, serving, (i < 4));
            end
        end
    endtask

    task automatic test_point();
        wait_play();
        tick(1, 0, 0);
        n_checks++;
        if (p1_score !== 4'd1 || serving !== 1'b1) begin
            n_fail++;
            $display("FAIL p1_point: p1=%0d serving=%b required 1 1", p1_score, serving);
        end
        tick(0, 1, 0);
        n_checks++;
        if (p2_score !== 4'd0 || p1_score !== 4'd1) begin
            n_fail++;
            $display("FAIL point_in_hold: p1=%0d p2=%0d required 1 0", p1_score, p2_score);
        end
    endtask

    task automatic test_simultaneous();
        wait_play();
        tick(1, 1, 0);
        n_checks++;
        if (p1_score !== 4'd2 || p2_score !== 4'd0) begin
            n_fail++;
            $display("FAIL simultaneous: p1=%0d p2=%0d required 2 0", p1_score, p2_score);
        end
    endtask

    task automatic test_win();
        tick(0, 0, 1);
        for (int i = 0; i < 3; i++) begin wait_play(); tick(0, 1, 0); end
        n_checks++;
        if (game_over !== 1'b1 || winner !== 1'b1 || p2_score !== 4'd3 || serving !== 1'b0) begin
            n_fail++;
            $display("FAIL p2_wins: go=%b win=%b p2=%0d srv=%b required 1 1 3 0", game_over, winner, p2_score, serving);
        end
        for (int i = 0; i < 6; i++) tick(i[0], !i[0], 0);
        n_checks++;
        if (p1_score !== 4'd0 || p2_score !== 4'd3 || game_over !== 1'b1) begin
            n_fail++;
            $display("FAIL over_ignores_points: p1=%0d p2=%0d go=%b required 0 3 1", p1_score, p2_score, game_over);
        end
        tick(0, 0, 1);
        n_checks++;
        if (p1_score !== 4'd0 || p2_score !== 4'd0 || game_over !== 1'b0 || serving !== 1'b1 || winner !== 1'b0) begin
            n_fail++;
            $display("FAIL new_game: p1=%0d p2=%0d go=%b srv=%b win=%b required 0 0 0 1 0",
                     p1_score, p2_score, game_over, serving, winner);
        end
        wait_play();
        tick(1, 0, 1);
        n_checks++;
        if (p1_score !== 4'd0 || serving !== 1'b1) begin
            n_fail++;
            $display("FAIL new_game_override: p1=%0d srv=%b required 0 1", p1_score, serving);
        end
    endtask

    task automatic test_random_game();
        for (int i = 0; i < 600; i++) begin
            tick(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 60) == 0);
            n_checks++;
            if ({p1_score, p2_score, serving, game_over, winner} !==
                {4'(m_p1), 4'(m_p2), m_state == 0, m_state == 2, m_win}) begin
                n_fail++;
                $display("FAIL random_game cyc %0d: p1=%0d p2=%0d srv=%b go=%b win=%b required %0d %0d %b %b %b",
                         i, p1_score, p2_score, serving, game_over, winner,
                         m_p1, m_p2, m_state == 0, m_state == 2, m_win);
            end
        end
    endtask

    task automatic test_raster();
        tick(0, 0, 1);
        wait_play(); tick(1, 0, 0);
        wait_play(); tick(0, 1, 0);
        wait_play(); tick(0, 1, 0);
        hpos = 10'd0; vpos = 10'd0; tick(0, 0, 0);
        hpos = 10'(LX + 4); vpos = 10'(DY); tick(0, 0, 0);
        hpos = 10'd700; vpos = 10'd500; tick(0, 0, 0);
        n_checks++;
        if (pixel_on !== 1'b1) begin
            n_fail++; $display("FAIL pix_one_top_row: pixel_on=%b required 1", pixel_on);
        end
        hpos = 10'(LX); vpos = 10'(DY + 10); tick(0, 0, 0);
        hpos = 10'd700; vpos = 10'd500; tick(0, 0, 0);
        n_checks++;
        if (pixel_on !== 1'b0) begin
            n_fail++; $display("FAIL pix_one_row10: pixel_on=%b required 0", pixel_on);
        end
        hpos = 10'(RX + 3); vpos = 10'(DY + 5); tick(0, 0, 0);
        n_checks++;
        if (digit_sel !== 4'd2) begin
            n_fail++; $display("FAIL sel_right: digit_sel=%0d required 2", digit_sel);
        end
        for (int i = 0; i < 400; i++) begin
            hpos = 10'($urandom_range(235, 405)); vpos = 10'($urandom_range(35, 80));
            tick(0, 0, 0);
            n_checks++;
            if (pixel_on !== m_px || digit_sel !== 4'(m_sel)) begin
                n_fail++;
                $display("FAIL raster_rand %0d: pix=%b sel=%0d required %b %0d", i, pixel_on, digit_sel, m_px, m_sel);
            end
        end
        hpos = 10'd700; vpos = 10'd500;
    endtask

    task automatic test_midframe();
        wait_play(); tick(1, 0, 0);
        hpos = 10'(LX); vpos = 10'(DY); tick(0, 0, 0);
        hpos = 10'd700; vpos = 10'd500; tick(0, 0, 0);
        n_checks++;
        if (pixel_on !== 1'b1 || p1_score !== 4'd2) begin
            n_fail++; $display("FAIL midframe_old: pix=%b p1=%0d required 1 2", pixel_on, p1_score);
        end
        hpos = 10'd0; vpos = 10'd0; tick(0, 0, 0);
        hpos = 10'(LX); vpos = 10'(DY); tick(0, 0, 0);
        hpos = 10'd700; vpos = 10'd500; tick(0, 0, 0);
        n_checks++;
        if (pixel_on !== 1'b0) begin
            n_fail++; $display("FAIL midframe_new: pixel_on=%b required 0", pixel_on);
        end
    endtask

    task automatic test_reset_flush();
        hpos = 10'(LX + 4); vpos = 10'(DY);
        tick(0, 0, 0); tick(0, 0, 0);
        n_checks++;
        if (pixel_on !== 1'b1) begin
            n_fail++; $display("FAIL flush_setup: pixel_on=%b required 1", pixel_on);
        end
        rst_n = 1'b0; tick(0, 0, 0);
        n_checks++;
        if (pixel_on !== 1'b0 || digit_sel !== 4'd0 || p1_score !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_flush: pix=%b sel=%0d p1=%0d required 0 0 0", pixel_on, digit_sel, p1_score);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; p1_point = 1'b0; p2_point = 1'b0; new_game = 1'b0;
        hpos = 10'd700; vpos = 10'd500;
        model_reset();
        test_reset();
        test_point();
        test_simultaneous();
        test_win();
        test_random_game();
        test_raster();
        test_midframe();
        test_reset_flush();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
